// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve
//  Description : Conditional branch resolution for the MIPS datapath.
//                It evaluates BEQ/BNE/BGTZ/BLEZ/BLTZ/BGEZ/BLTZAL/BGEZAL and
//                produces the redirect and link PCs. A bimodal table of
//                2-bit counters supplies fetch predictions. Saturating
//                counters track resolved branches and mispredicts.
//  Revision    : 1.0  initial release
// ============================================================================
module branch_resolve #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int BHT_DEPTH = 16,
  parameter int CW        = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] f_pc,
  output logic          f_pred,
  input  logic          in_valid,
  input  logic [31:0]   ins,
  input  logic [AW-1:0] pc,
  input  logic [DW-1:0] dinA,
  input  logic [DW-1:0] dinB,
  input  logic          pred_taken,
  input  logic          flush,
  output logic          out_valid,
  output logic          branch,
  output logic          mispredict,
  output logic [AW-1:0] redirect_pc,
  output logic          link,
  output logic [AW-1:0] link_pc,
  output logic [CW-1:0] br_cnt,
  output logic [CW-1:0] mis_cnt
);

  // Table index width; a depth of 2 still needs one index bit.
  localparam int IW = (BHT_DEPTH > 2) ? $clog2(BHT_DEPTH) : 1;

  localparam logic [5:0] C_OP_REGIMM = 6'b000001;
  localparam logic [5:0] C_OP_BEQ    = 6'b000100;
  localparam logic [5:0] C_OP_BNE    = 6'b000101;
  localparam logic [5:0] C_OP_BLEZ   = 6'b000110;
  localparam logic [5:0] C_OP_BGTZ   = 6'b000111;

  localparam logic [4:0] C_RT_BLTZ   = 5'b00000;
  localparam logic [4:0] C_RT_BGEZ   = 5'b00001;
  localparam logic [4:0] C_RT_BLTZAL = 5'b10000;
  localparam logic [4:0] C_RT_BGEZAL = 5'b10001;

  localparam logic [1:0] C_BHT_INIT  = 2'b01;
  localparam logic [1:0] C_BHT_MAX   = 2'b11;
  localparam logic [1:0] C_BHT_MIN   = 2'b00;

  localparam logic [AW-1:0] C_FOUR  = AW'(4);
  localparam logic [AW-1:0] C_EIGHT = AW'(8);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  // --------------------------------------------------------------------------
  // Decode and condition evaluation
  // --------------------------------------------------------------------------
  logic [5:0]    w_op;
  logic [4:0]    w_rt;
  logic          w_a_zero;
  logic          w_a_neg;
  logic          w_a_eq_b;
  logic          w_is_branch;
  logic          w_taken;
  logic          w_is_link;

  assign w_op     = ins[31:26];
  assign w_rt     = ins[20:16];
  assign w_a_zero = (dinA == '0);
  assign w_a_neg  = dinA[DW-1];
  assign w_a_eq_b = (dinA == dinB);

  // Classify the instruction and evaluate its branch condition.
  always_comb begin
    w_is_branch = 1'b0;
    w_taken     = 1'b0;
    w_is_link   = 1'b0;
    case (w_op)
      C_OP_BEQ: begin
        w_is_branch = 1'b1;
        w_taken     = w_a_eq_b;
      end
      C_OP_BNE: begin
        w_is_branch = 1'b1;
        w_taken     = ~w_a_eq_b;
      end
      C_OP_BGTZ: begin
        w_is_branch = 1'b1;
        w_taken     = ~w_a_neg & ~w_a_zero;
      end
      C_OP_BLEZ: begin
        w_is_branch = 1'b1;
        w_taken     = w_a_neg | w_a_zero;
      end
      C_OP_REGIMM: begin
        case (w_rt)
          C_RT_BLTZ: begin
            w_is_branch = 1'b1;
            w_taken     = w_a_neg;
          end
          C_RT_BGEZ: begin
            w_is_branch = 1'b1;
            w_taken     = ~w_a_neg;
          end
          C_RT_BLTZAL: begin
            w_is_branch = 1'b1;
            w_taken     = w_a_neg;
            w_is_link   = 1'b1;
          end
          C_RT_BGEZAL: begin
            w_is_branch = 1'b1;
            w_taken     = ~w_a_neg;
            w_is_link   = 1'b1;
          end
          default: begin
            w_is_branch = 1'b0;
          end
        endcase
      end
      default: begin
        w_is_branch = 1'b0;
      end
    endcase
  end

  // Accepted requests are the only ones allowed to touch any state.
  logic w_accept;
  assign w_accept = in_valid & ~flush & w_is_branch;

  // --------------------------------------------------------------------------
  // PC arithmetic (all modulo 2^AW)
  // --------------------------------------------------------------------------
  // Sign-extend the word offset into a vector wide enough for any AW, then
  // keep the low AW bits so narrow PCs wrap silently.
  logic [AW+17:0] w_off_ext;
  logic [AW-1:0]  w_off;
  logic [AW-1:0]  w_fall_pc;
  logic [AW-1:0]  w_target_pc;
  logic [AW-1:0]  w_redirect;
  logic [AW-1:0]  w_link_pc;

  assign w_off_ext   = {{AW{ins[15]}}, ins[15:0], 2'b00};
  assign w_off       = w_off_ext[AW-1:0];
  assign w_fall_pc   = pc + C_FOUR;
  assign w_target_pc = w_fall_pc + w_off;
  assign w_redirect  = w_taken ? w_target_pc : w_fall_pc;
  assign w_link_pc   = pc + C_EIGHT;

  // --------------------------------------------------------------------------
  // Branch history table
  // --------------------------------------------------------------------------
  logic [1:0]    bht_q [BHT_DEPTH];
  logic [IW-1:0] w_f_idx;
  logic [IW-1:0] w_u_idx;
  logic [1:0]    w_u_cnt;
  logic [1:0]    w_u_cnt_d;

  assign w_f_idx = f_pc[IW+1:2];
  assign w_u_idx = pc[IW+1:2];
  assign w_u_cnt = bht_q[w_u_idx];

  // The lookup reads the stored state, so a same-cycle update is not visible.
  assign f_pred = bht_q[w_f_idx][1];

  // Saturating step of the counter being trained.
  always_comb begin
    w_u_cnt_d = w_u_cnt;
    if (w_taken) begin
      if (w_u_cnt != C_BHT_MAX) w_u_cnt_d = w_u_cnt + 2'b01;
    end else begin
      if (w_u_cnt != C_BHT_MIN) w_u_cnt_d = w_u_cnt - 2'b01;
    end
  end

  generate
    for (genvar gi = 0; gi < BHT_DEPTH; gi++) begin : g_bht
      // One counter per entry; only the indexed entry is trained on accept.
      always_ff @(posedge clk) begin
        if (rst) begin
          bht_q[gi] <= C_BHT_INIT;
        end else if (w_accept && (w_u_idx == IW'(gi))) begin
          bht_q[gi] <= w_u_cnt_d;
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Registered resolution outputs
  // --------------------------------------------------------------------------
  logic          out_valid_q;
  logic          branch_q,     branch_d;
  logic          mispredict_q, mispredict_d;
  logic          link_q,       link_d;
  logic [AW-1:0] redirect_q,   redirect_d;
  logic [AW-1:0] link_pc_q,    link_pc_d;

  // Outputs load on accept and otherwise hold their last reported values.
  always_comb begin
    branch_d     = branch_q;
    mispredict_d = mispredict_q;
    link_d       = link_q;
    redirect_d   = redirect_q;
    link_pc_d    = link_pc_q;
    if (w_accept) begin
      branch_d     = w_taken;
      mispredict_d = w_taken ^ pred_taken;
      link_d       = w_is_link;
      redirect_d   = w_redirect;
      link_pc_d    = w_link_pc;
    end
  end

  // Output register; out_valid pulses once per accepted request.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      branch_q     <= 1'b0;
      mispredict_q <= 1'b0;
      link_q       <= 1'b0;
      redirect_q   <= '0;
      link_pc_q    <= '0;
    end else begin
      out_valid_q  <= w_accept;
      branch_q     <= branch_d;
      mispredict_q <= mispredict_d;
      link_q       <= link_d;
      redirect_q   <= redirect_d;
      link_pc_q    <= link_pc_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign branch      = branch_q;
  assign mispredict  = mispredict_q & out_valid_q;
  assign redirect_pc = redirect_q;
  assign link        = link_q;
  assign link_pc     = link_pc_q;

  // --------------------------------------------------------------------------
  // Statistics
  // --------------------------------------------------------------------------
  logic [CW-1:0] br_cnt_q,  br_cnt_d;
  logic [CW-1:0] mis_cnt_q, mis_cnt_d;

  // Counters stop at all-ones rather than wrapping.
  always_comb begin
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (w_accept) begin
      if (~&br_cnt_q) br_cnt_d = br_cnt_q + C_ONE;
      if ((w_taken ^ pred_taken) && ~&mis_cnt_q) mis_cnt_d = mis_cnt_q + C_ONE;
    end
  end

  // Statistics register.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign br_cnt  = br_cnt_q;
  assign mis_cnt = mis_cnt_q;

  // Register-number fields and PC bits outside the table index carry no
  // meaning for resolution.
  logic w_unused;
  assign w_unused = ^{ins[25:21], f_pc, pc};

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_resolve
//  Description : Directed self-checking bench for branch_resolve.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] f_pc;
  logic        f_pred;
  logic        in_valid;
  logic [31:0] ins;
  logic [31:0] pc;
  logic [31:0] dinA;
  logic [31:0] dinB;
  logic        pred_taken;
  logic        flush;
  logic        out_valid;
  logic        branch;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        link;
  logic [31:0] link_pc;
  logic [3:0]  br_cnt;
  logic [3:0]  mis_cnt;

  int tests = 0;
  int fails = 0;

  branch_resolve #(
    .DW(32), .AW(32), .BHT_DEPTH(16), .CW(4)
  ) dut (
    .clk(clk), .rst(rst), .f_pc(f_pc), .f_pred(f_pred),
    .in_valid(in_valid), .ins(ins), .pc(pc), .dinA(dinA), .dinB(dinB),
    .pred_taken(pred_taken), .flush(flush), .out_valid(out_valid),
    .branch(branch), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .link(link), .link_pc(link_pc), .br_cnt(br_cnt), .mis_cnt(mis_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are stable 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b, input logic pt);
    in_valid = 1'b1; ins = i; pc = p; dinA = a; dinB = b; pred_taken = pt;
    step();
    in_valid = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [31:0] addr, input logic exp);
    f_pc = addr;
    #1;
    chk(tag, {31'd0, f_pred}, {31'd0, exp});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; ins = '0; pc = '0; dinA = '0; dinB = '0;
    pred_taken = 1'b0; flush = 1'b0; f_pc = '0;
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_branch", {31'd0, branch}, 32'd0);
    chk("rst_mispredict", {31'd0, mispredict}, 32'd0);
    chk("rst_link", {31'd0, link}, 32'd0);
    chk("rst_redirect", redirect_pc, 32'd0);
    chk("rst_link_pc", link_pc, 32'd0);
    chk("rst_br_cnt", {28'd0, br_cnt}, 32'd0);
    chk("rst_mis_cnt", {28'd0, mis_cnt}, 32'd0);
    for (int i = 0; i < 16; i++) lookup("rst_f_pred", 32'(i * 4), 1'b0);

    // BEQ taken, predicted not-taken: idx0 01->10
    issue(32'h1085_0003, 32'h100, 32'd5, 32'd5, 1'b0);
    chk("beq_valid", {31'd0, out_valid}, 32'd1);
    chk("beq_branch", {31'd0, branch}, 32'd1);
    chk("beq_mispredict", {31'd0, mispredict}, 32'd1);
    chk("beq_redirect", redirect_pc, 32'h110);
    chk("beq_link", {31'd0, link}, 32'd0);
    chk("beq_link_pc", link_pc, 32'h108);
    chk("beq_br_cnt", {28'd0, br_cnt}, 32'd1);
    chk("beq_mis_cnt", {28'd0, mis_cnt}, 32'd1);
    lookup("beq_f_pred", 32'h100, 1'b1);
    step();
    chk("beq_pulse_end", {31'd0, out_valid}, 32'd0);
    chk("beq_hold_redirect", redirect_pc, 32'h110);
    chk("beq_mispredict_qual", {31'd0, mispredict}, 32'd0);

    // BGEZAL not taken: idx0 10->01
    issue(32'h0411_0000, 32'h200, 32'h8000_0000, 32'd0, 1'b0);
    chk("bgezal_branch", {31'd0, branch}, 32'd0);
    chk("bgezal_link", {31'd0, link}, 32'd1);
    chk("bgezal_link_pc", link_pc, 32'h208);
    chk("bgezal_redirect", redirect_pc, 32'h204);
    chk("bgezal_mispredict", {31'd0, mispredict}, 32'd0);
    chk("bgezal_br_cnt", {28'd0, br_cnt}, 32'd2);
    lookup("bgezal_f_pred", 32'h200, 1'b0);

    // Three taken at 0x40 (idx0): 01->10->11->11
    for (int i = 0; i < 3; i++) issue(32'h1085_0003, 32'h40, 32'd7, 32'd7, 1'b1);
    chk("sat_redirect", redirect_pc, 32'h50);
    chk("sat_link_cleared", {31'd0, link}, 32'd0);
    lookup("sat3_f_pred", 32'h40, 1'b1);
    issue(32'h1085_0003, 32'h40, 32'd7, 32'd7, 1'b1);
    lookup("sat4_f_pred", 32'h40, 1'b1);

    // Not-taken BNE at 0x40 while looking up the same index
    in_valid = 1'b1; ins = 32'h1485_0003; pc = 32'h40; dinA = 32'd9; dinB = 32'd9;
    pred_taken = 1'b1; f_pc = 32'h40;
    #1;
    chk("rbw_f_pred", {31'd0, f_pred}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("bne_nt_branch", {31'd0, branch}, 32'd0);
    chk("bne_nt_mispredict", {31'd0, mispredict}, 32'd1);
    chk("bne_nt_redirect", redirect_pc, 32'h44);
    lookup("ctr10_f_pred", 32'h40, 1'b1);
    issue(32'h1485_0003, 32'h40, 32'd9, 32'd9, 1'b1);
    lookup("ctr01_f_pred", 32'h40, 1'b0);
    chk("mid_br_cnt", {28'd0, br_cnt}, 32'd8);
    chk("mid_mis_cnt", {28'd0, mis_cnt}, 32'd3);

    // BGTZ / BLEZ at 0x4 (idx1) and a wrapping BLTZ at 0xC
    issue(32'h1C80_0002, 32'h4, 32'd1, 32'd0, 1'b1);
    chk("bgtz_branch", {31'd0, branch}, 32'd1);
    chk("bgtz_redirect", redirect_pc, 32'h10);
    issue(32'h1880_0000, 32'h4, 32'd0, 32'd0, 1'b1);
    chk("blez_branch", {31'd0, branch}, 32'd1);
    chk("blez_redirect", redirect_pc, 32'h8);
    lookup("idx1_f_pred", 32'h4, 1'b1);
    issue(32'h0480_FFF8, 32'hC, 32'hFFFF_FFFF, 32'd0, 1'b1);
    chk("bltz_wrap_redirect", redirect_pc, 32'hFFFF_FFF0);
    chk("bltz_mispredict", {31'd0, mispredict}, 32'd0);

    // BLTZAL taken
    issue(32'h0410_0000, 32'h304, 32'hFFFF_FFFF, 32'd0, 1'b1);
    chk("bltzal_branch", {31'd0, branch}, 32'd1);
    chk("bltzal_link", {31'd0, link}, 32'd1);
    chk("bltzal_link_pc", link_pc, 32'h30C);
    chk("bltzal_redirect", redirect_pc, 32'h308);
    chk("bltzal_br_cnt", {28'd0, br_cnt}, 32'd12);

    // Flushed BNE, then a non-branch
    flush = 1'b1;
    issue(32'h1485_0003, 32'h100, 32'd1, 32'd2, 1'b0);
    flush = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_br_cnt", {28'd0, br_cnt}, 32'd12);
    chk("flush_mis_cnt", {28'd0, mis_cnt}, 32'd3);
    lookup("flush_f_pred", 32'h100, 1'b0);
    issue(32'h0000_0020, 32'h100, 32'd1, 32'd1, 1'b0);
    chk("add_valid", {31'd0, out_valid}, 32'd0);
    chk("add_br_cnt", {28'd0, br_cnt}, 32'd12);
    chk("add_hold_redirect", redirect_pc, 32'h308);
    lookup("add_f_pred", 32'h100, 1'b0);

    // 20 mispredicted branches at 0x8 (idx2): both counters saturate
    for (int i = 0; i < 20; i++) issue(32'h1085_0003, 32'h8, 32'd3, 32'd3, 1'b0);
    chk("sat_mis_cnt", {28'd0, mis_cnt}, 32'd15);
    chk("sat_br_cnt", {28'd0, br_cnt}, 32'd15);
    lookup("idx2_f_pred", 32'h8, 1'b1);

    // Reset alongside a valid request
    rst = 1'b1;
    issue(32'h1085_0003, 32'h8, 32'd3, 32'd3, 1'b0);
    rst = 1'b0;
    chk("rst2_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2_br_cnt", {28'd0, br_cnt}, 32'd0);
    chk("rst2_mis_cnt", {28'd0, mis_cnt}, 32'd0);
    chk("rst2_redirect", redirect_pc, 32'd0);
    lookup("rst2_f_pred", 32'h8, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_resolve.md
# branch_resolve

Parametrised branch resolution unit for the MIPS pipeline datapath. It evaluates all conditional branches (BEQ, BNE, BGTZ, BLEZ, BLTZ, BGEZ, BLTZAL, BGEZAL) over a configurable data width and computes the branch target and the fall-through PC. A bimodal branch history table (BHT) of 2-bit saturating counters serves fetch-stage predictions, and the unit reports mispredictions with a redirect PC one cycle after resolution input. It also supplies link data for the and-link forms and keeps saturating branch and mispredict counters.

## Interface
Parameters:
- `DW`, 32: operand width of `dinA`/`dinB`.
- `AW`, 32: PC width.
- `BHT_DEPTH`, 16: number of BHT entries; power of two, at least 2.
- `CW`, 16: width of the statistics counters.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `f_pc`  in  AW  fetch-stage PC for prediction lookup.
- `f_pred`  out  1  prediction for `f_pc`; combinational, 1 = taken.
- `in_valid`  in  1  resolve request valid this cycle.
- `ins`  in  32  instruction word.
- `pc`  in  AW  PC of the instruction.
- `dinA`  in  DW  rs operand, forwarded.
- `dinB`  in  DW  rt operand, forwarded.
- `pred_taken`  in  1  prediction the fetch stage used for this instruction.
- `flush`  in  1  kills the request presented in the same cycle.
- `out_valid`  out  1  registered; a resolved branch is being reported.
- `branch`  out  1  registered; actual outcome, 1 = taken.
- `mispredict`  out  1  registered; `branch != pred_taken`, qualified by `out_valid`.
- `redirect_pc`  out  AW  registered; target if taken, otherwise `pc+4`.
- `link`  out  1  registered; a BLTZAL or BGEZAL was resolved (asserted whether or not it is taken).
- `link_pc`  out  AW  registered; `pc+8`.
- `br_cnt`  out  CW  count of resolved branches; saturating.
- `mis_cnt`  out  CW  count of mispredicts; saturating.

## Operation
- Decode: `op = ins[31:26]`, `rt = ins[20:16]`.
  - BEQ 000100: taken if A==B.
  - BNE 000101: taken if A!=B.
  - BGTZ 000111: taken if signed A>0.
  - BLEZ 000110: taken if signed A<=0.
  - op 000001: dispatch on `rt`.
    - 00000 BLTZ: taken if signed A<0.
    - 00001 BGEZ: taken if signed A>=0.
    - 10000 BLTZAL: as BLTZ, plus link.
    - 10001 BGEZAL: as BGEZ, plus link.
- Any other op, or op 000001 with any other `rt`, is a non-branch. A non-branch produces `out_valid=0`, no BHT update and no counter change.
- BLTZAL/BGEZAL report `link=1` whether taken or not. All other cases report `link=0`.
- Arithmetic:
  - Comparisons use the full DW bits, signed where stated.
  - Target = `pc + 4 + (sign_extend(ins[15:0]) << 2)`, truncated to AW bits; wrap-around is silent.
  - `link_pc = pc + 8`, mod 2^AW.
- BHT:
  - Index = `pc[log2(BHT_DEPTH)+1:2]`; the same slice of `f_pc` is used for lookup.
  - `f_pred` = counter[1] at that index.
  - Update on an accepted branch: taken increments the counter, not-taken decrements it. Counters saturate at 11 and 00.
- Accept: a request is accepted when `in_valid & ~flush & is_branch`. Only accepted requests update outputs, the BHT and the counters.
- Statistics:
  - `br_cnt` increments on each accept.
  - `mis_cnt` increments on an accept whose outcome differs from `pred_taken`.
  - Both hold at all-ones once saturated.
- Reset (`rst=1` at an edge):
  - `out_valid`, `branch`, `mispredict`, `link` = 0.
  - `redirect_pc`, `link_pc` = 0.
  - `br_cnt`, `mis_cnt` = 0.
  - Every BHT entry = 01 (weakly not-taken).
  - `rst` has priority over `in_valid` and `flush`. A request presented in the reset cycle is dropped.

## Timing
- Resolve latency: 1 cycle. Request at edge N appears on the outputs after edge N+1.
- No backpressure; one request can be accepted every cycle.
- `out_valid` is a one-cycle pulse per accepted request. The other registered outputs hold their last value when `out_valid=0`.
- The BHT write and the counter updates take effect at the same edge as the outputs.
- `f_pred` is a combinational read. If the fetch lookup and an update hit the same index in the same cycle, `f_pred` returns the pre-update value (read-before-write).
- `flush` affects only the request in its own cycle; an output already registered is not retracted.
- Back-to-back accepts to the same index apply sequentially: two taken branches move the counter 01→10→11.

## Test plan
- **Reset.** Drive `rst` for one cycle, then `f_pc` = 0x0, 0x4, …, 0x3C.
  Expected: `f_pred=0` for every index; all outputs and counters read 0.
- **BEQ taken, predicted not-taken.** `ins=0x1085_0003`, `pc=0x100`, A=B=5, `pred_taken=0`.
  Expected, next cycle: `out_valid=1`, `branch=1`, `mispredict=1`, `redirect_pc=0x110`, `br_cnt=1`, `mis_cnt=1`.
  Expected, then: the BHT entry for `pc=0x100` reads 10, so `f_pred=1`.
- **BGEZAL not taken.** op 000001, `rt=10001`, A=0x8000_0000, `pc=0x200`, `pred_taken=0`.
  Expected: `branch=0`, `link=1`, `link_pc=0x208`, `redirect_pc=0x204`, `mispredict=0`.
- **Saturation and read-before-write.** Three taken branches at `pc=0x40`, then hold `f_pc=0x40` during a fourth taken branch.
  Expected: the counter reads 11 and stays 11 after the fourth. During a subsequent not-taken update, `f_pred` shows 1 in the update cycle and the stored counter is 10 afterwards.
- **Flush and non-branch.** A BNE with `flush=1`, followed by `ins=0x0000_0020` (ADD) with `in_valid=1`.
  Expected: `out_valid` stays 0, counters unchanged, BHT unchanged.
- **Counter saturation and reset mid-stream.** With `CW=4`, issue 20 mispredicted branches.
  Expected: `mis_cnt=15` and holds. Asserting `rst` alongside a valid request gives `out_valid=0` next cycle and clears both counters.
